// File: rtl/method_test_sequencer.sv
// Self-check sequencer for generated method handshakes.
// Walks channels in order: pulse req, wait busy low, compare ret.
module method_test_sequencer #(
  parameter int NUM_CH       = 4,
  parameter int RET_W        = 32,
  parameter int SETTLE       = 5,
  parameter int TIMEOUT      = 1000000,
  parameter int CNT_W        = 32,
  parameter int STOP_ON_FAIL = 1,
  localparam int FCW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int WCW = $clog2(TIMEOUT + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [NUM_CH-1:0]       ch_enable,
  input  logic [NUM_CH*RET_W-1:0] expected,
  input  logic [NUM_CH-1:0]       busy,
  input  logic [NUM_CH*RET_W-1:0] ret,
  output logic [NUM_CH-1:0]       req,
  output logic                    running,
  output logic                    done,
  output logic                    pass,
  output logic [FCW-1:0]          fail_ch,
  output logic                    fail_timeout,
  output logic                    fail_mismatch,
  output logic [CNT_W-1:0]        cycles
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_SETTLE,
    S_WAIT,
    S_CHECK,
    S_NEXT,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [FCW-1:0]   ch_q, ch_d;
  logic [WCW-1:0]   wcnt_q, wcnt_d;
  logic [FCW-1:0]   fch_q, fch_d;
  logic             fto_q, fto_d;
  logic             fmm_q, fmm_d;
  logic             pass_q, pass_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;

  logic ch_en;
  logic ch_busy;
  logic mism;
  logic any_fail;
  logic run;

  assign ch_en    = ch_enable[ch_q];
  assign ch_busy  = busy[ch_q];
  assign mism     = ret[ch_q*RET_W +: RET_W]
                 != expected[ch_q*RET_W +: RET_W];
  assign any_fail = fto_q | fmm_q;
  assign run      = (state_q != S_IDLE) && (state_q != S_DONE);

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    wcnt_d  = '0;
    fch_d   = fch_q;
    fto_d   = fto_q;
    fmm_d   = fmm_q;
    pass_d  = pass_q;
    cyc_d   = cyc_q;
    if (run && !(&cyc_q)) cyc_d = cyc_q + 1'b1;
    // wait counter runs from the REQ cycle (value 0) through WAIT
    if (state_q == S_REQ || state_q == S_SETTLE || state_q == S_WAIT)
      wcnt_d = wcnt_q + 1'b1;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_REQ;
          ch_d    = '0;
          fch_d   = '0;
          fto_d   = 1'b0;
          fmm_d   = 1'b0;
          pass_d  = 1'b0;
          cyc_d   = '0;
        end
      end
      S_REQ: state_d = ch_en ? S_SETTLE : S_NEXT;
      S_SETTLE: begin
        if (wcnt_q >= WCW'(SETTLE)) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!ch_busy) begin
          state_d = S_CHECK;
        end else if (wcnt_q == WCW'(TIMEOUT - 1)) begin
          fto_d   = 1'b1;
          if (!any_fail) fch_d = ch_q;
          state_d = S_NEXT;
        end
      end
      S_CHECK: begin
        if (mism) begin
          fmm_d = 1'b1;
          if (!any_fail) fch_d = ch_q;
        end
        state_d = S_NEXT;
      end
      S_NEXT: begin
        if (ch_q == FCW'(NUM_CH - 1) ||
            (STOP_ON_FAIL != 0 && any_fail)) begin
          state_d = S_DONE;
          pass_d  = !any_fail;
        end else begin
          ch_d    = ch_q + 1'b1;
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      wcnt_q  <= '0;
      fch_q   <= '0;
      fto_q   <= 1'b0;
      fmm_q   <= 1'b0;
      pass_q  <= 1'b0;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      wcnt_q  <= wcnt_d;
      fch_q   <= fch_d;
      fto_q   <= fto_d;
      fmm_q   <= fmm_d;
      pass_q  <= pass_d;
      cyc_q   <= cyc_d;
    end
  end

  always_comb begin
    req = '0;
    if (state_q == S_REQ && ch_en) req[ch_q] = 1'b1;
  end

  assign running       = run;
  assign done          = (state_q == S_DONE);
  assign pass          = pass_q;
  assign fail_ch       = fch_q;
  assign fail_timeout  = fto_q;
  assign fail_mismatch = fmm_q;
  assign cycles        = cyc_q;

endmodule
